vga_fifo_reader: RTL and testbench

Read-side consumer of the cross-clock pixel FIFO: generates 640x480@60 VGA timing in the 25 MHz pixel domain, pops one 24-bit RGB word per active pixel, and drives registered sync and colour outputs to the DAC/pins. It pairs with the writer path that fills the FIFO from the display ROM at 100 MHz. It also detects and counts FIFO underflow, substituting black for missing pixels.

---
 rtl/vga_fifo_reader.sv | 187 ++++++++++++++++++
 tb/tb_vga_fifo_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fifo_reader.sv
// vga_fifo_reader: 640x480@60 VGA timing in the pixel clock domain, popping one RGB word per active pixel.
// Define UNDERFLOW_CNT_EN to build the per-frame underflow counter behind underflow_cnt (tied to 0 otherwise).
module vga_fifo_reader #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic        clk_25mhz,
   input  logic        rst,
   input  logic [23:0] fifo_data,
   input  logic        fifo_empty,
   output logic        rd_fifo,
   output logic        hsync,
   output logic        vsync,
   output logic [7:0]  pixel_r,
   output logic [7:0]  pixel_g,
   output logic [7:0]  pixel_b,
   output logic        frame_start,
   output logic        underflow,
   output logic [15:0] underflow_cnt
);

   localparam int unsigned CNT_W  = 10;
   localparam int unsigned PIX_W  = 24;
   localparam int unsigned UCNT_W = 16;
   localparam int unsigned H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {
      WAIT_FILL = 1'b0,
      RUN       = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;

   // stage 0 decode of the registered counters
   logic               de0, hs0, vs0, fs0, uf0;

   // stage 1
   logic               de1_q, hs1_q, vs1_q, pop1_q, fs1_q;

   // stage 2 (pins)
   logic               hsync_q, vsync_q, frame_start_q;
   logic [PIX_W-1:0]   pix_q, pix_d;
   logic               underflow_q, underflow_d;

   // State register and raster counters
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_FILL;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Next state, counter advance and stage-0 timing decode
   always_comb begin
      state_d = state_q;
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      de0     = 1'b0;
      hs0     = 1'b1;
      vs0     = 1'b1;
      fs0     = 1'b0;

      case (state_q)
         WAIT_FILL: begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (!fifo_empty) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (h_cnt_q == H_LAST) begin
               h_cnt_d = '0;
               v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
               h_cnt_d = h_cnt_q + CNT_W'(1);
            end
            de0 = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
            hs0 = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
            vs0 = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
            fs0 = (h_cnt_q == '0) && (v_cnt_q == '0);
         end
      endcase
   end

   // Pop only when a word is there; a missing word becomes a black pixel and is never skipped
   assign rd_fifo = de0 & ~fifo_empty;
   assign uf0     = de0 & fifo_empty;

   always_comb begin
      pix_d       = (pop1_q && de1_q) ? fifo_data : '0;
      underflow_d = underflow_q | uf0;
   end

   // Stage 1 and pin registers; fifo_data is valid the clock after rd_fifo, aligning with pop1
   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         de1_q         <= 1'b0;
         hs1_q         <= 1'b1;
         vs1_q         <= 1'b1;
         pop1_q        <= 1'b0;
         fs1_q         <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
         pix_q         <= '0;
         underflow_q   <= 1'b0;
      end else begin
         de1_q         <= de0;
         hs1_q         <= hs0;
         vs1_q         <= vs0;
         pop1_q        <= rd_fifo;
         fs1_q         <= fs0;
         hsync_q       <= hs1_q;
         vsync_q       <= vs1_q;
         frame_start_q <= fs1_q;
         pix_q         <= pix_d;
         underflow_q   <= underflow_d;
      end
   end

`ifdef UNDERFLOW_CNT_EN
   logic              frame_wrap;
   logic [UCNT_W-1:0] frame_uf_q, frame_uf_d;
   logic [UCNT_W-1:0] ucnt_q, ucnt_d;

   assign frame_wrap = (state_q == RUN) && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

   // Saturating per-frame count, published at the last blanking clock of the frame
   always_comb begin
      frame_uf_d = frame_uf_q;
      ucnt_d     = ucnt_q;
      if (frame_wrap) begin
         ucnt_d     = frame_uf_q;
         frame_uf_d = '0;
      end else if (uf0 && (frame_uf_q != '1)) begin
         frame_uf_d = frame_uf_q + UCNT_W'(1);
      end
   end

   always_ff @(posedge clk_25mhz or posedge rst) begin
      if (rst) begin
         frame_uf_q <= '0;
         ucnt_q     <= '0;
      end else begin
         frame_uf_q <= frame_uf_d;
         ucnt_q     <= ucnt_d;
      end
   end

   assign underflow_cnt = ucnt_q;
`else
   assign underflow_cnt = '0;
`endif

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign pixel_r     = pix_q[23:16];
   assign pixel_g     = pix_q[15:8];
   assign pixel_b     = pix_q[7:0];
   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_fifo_reader.sv
// Scoreboard bench for vga_fifo_reader on a reduced raster, with a FIFO model and frame-position reference model.
`timescale 1ns/1ps
module tb_vga_fifo_reader;

   localparam int HA  = 16;
   localparam int HFP = 4;
   localparam int HS  = 6;
   localparam int HB  = 4;
   localparam int VA  = 8;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VB  = 3;
   localparam int HT  = HA + HFP + HS + HB;
   localparam int VT  = VA + VFP + VS + VB;
   localparam int FT  = HT * VT;

   localparam int M_EMPTY = 0;
   localparam int M_FULL  = 1;
   localparam int M_HOLE  = 2;
   localparam int M_RAND  = 3;
   localparam int M_ALT   = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] fifo_data = '0;
   logic        fifo_empty = 1'b1;
   logic        rd_fifo, hsync, vsync, frame_start, underflow;
   logic [7:0]  pixel_r, pixel_g, pixel_b;
   logic [15:0] underflow_cnt;

   vga_fifo_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk_25mhz    (clk),
      .rst          (rst),
      .fifo_data    (fifo_data),
      .fifo_empty   (fifo_empty),
      .rd_fifo      (rd_fifo),
      .hsync        (hsync),
      .vsync        (vsync),
      .pixel_r      (pixel_r),
      .pixel_g      (pixel_g),
      .pixel_b      (pixel_b),
      .frame_start  (frame_start),
      .underflow    (underflow),
      .underflow_cnt(underflow_cnt)
   );

   always #20 clk = ~clk;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        fs;
      logic [23:0] rgb;
   } pins_t;

   pins_t exp_q[$];
   pins_t mon_e, mon_a;
   int    checks = 0;
   int    errors = 0;

   // reference model state
   bit running    = 1'b0;
   int k          = 0;
   int exp_pops   = 0;
   int rd_ptr     = 0;
   bit rd_latched = 1'b0;
   bit uf_seen    = 1'b0;
   int frame_uf   = 0;
   int exp_ucnt   = 0;

   function automatic logic [23:0] word(input int i);
      return 24'(i + 1);
   endfunction

   // Standard-read FIFO: dout updates on the clock edge after a read request
   always @(posedge clk) begin
      if (rd_latched) begin
         fifo_data <= word(rd_ptr);
         rd_ptr++;
      end
   end

   always @(posedge clk) begin
      #1;
      if (!rst && exp_q.size() >= 2) begin
         mon_e = exp_q.pop_front();
         mon_a = {hsync, vsync, frame_start, pixel_r, pixel_g, pixel_b};
         checks++;
         if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL pins t=%0t act hs=%b vs=%b fs=%b rgb=%06h exp hs=%b vs=%b fs=%b rgb=%06h",
                     $time, mon_a.hs, mon_a.vs, mon_a.fs, mon_a.rgb,
                     mon_e.hs, mon_e.vs, mon_e.fs, mon_e.rgb);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t act=%0h exp=%0h", name, $time, act, exp);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rd_fifo", 32'(rd_fifo), 32'd0);
      chk("rst_hsync", 32'(hsync), 32'd1);
      chk("rst_vsync", 32'(vsync), 32'd1);
      chk("rst_pixel", 32'({pixel_r, pixel_g, pixel_b}), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
      chk("rst_underflow_cnt", 32'(underflow_cnt), 32'd0);
   endtask

   // One pixel clock: drive fifo_empty, advance the model, queue the expected pin values
   task automatic step(input int mode);
      bit    e, de, rd_exp;
      int    x, y;
      pins_t p;
      @(negedge clk);
      chk("underflow", 32'(underflow), 32'(uf_seen));
      chk("underflow_cnt", 32'(underflow_cnt), 32'(exp_ucnt));
      x = k % HT;
      y = k / HT;
      case (mode)
         M_EMPTY: e = 1'b1;
         M_FULL:  e = 1'b0;
         M_HOLE:  e = running && (y == 0) && (x >= 10) && (x <= 12);
         M_RAND:  e = ($urandom_range(99) < 30);
         default: e = running ? k[0] : 1'b0;
      endcase
      fifo_empty = e;
      #1;
      rd_exp = 1'b0;
      p = '{hs: 1'b1, vs: 1'b1, fs: 1'b0, rgb: 24'h0};
      if (!running) begin
         if (!e) begin
            running = 1'b1;
            k = 0;
         end
      end else begin
         de     = (x < HA) && (y < VA);
         rd_exp = de && !e;
         p.hs   = !((x >= HA + HFP) && (x < HA + HFP + HS));
         p.vs   = !((y >= VA + VFP) && (y < VA + VFP + VS));
         p.fs   = (x == 0) && (y == 0);
         if (rd_exp) begin
            p.rgb = word(exp_pops);
            exp_pops++;
         end
         if (de && e) begin
            uf_seen = 1'b1;
            if (frame_uf < 65535) frame_uf++;
         end
         k++;
         if (k == FT) begin
            k = 0;
`ifdef UNDERFLOW_CNT_EN
            exp_ucnt = frame_uf;
`else
            exp_ucnt = 0;
`endif
            frame_uf = 0;
         end
      end
      exp_q.push_back(p);
      chk("rd_fifo", 32'(rd_fifo), 32'(rd_exp));
      rd_latched = rd_fifo;
   endtask

   task automatic run_to_frame_start(input int mode);
      int guard = 0;
      do begin
         step(mode);
         guard++;
      end while (!(running && k == 0) && guard < 4 * FT);
      if (guard >= 4 * FT) begin
         errors++;
         $display("FAIL frame_sync act=no_frame_start exp=frame_start_within_%0d", 4 * FT);
      end
   endtask

   task automatic run_frame(input int mode);
      for (int i = 0; i < FT; i++) step(mode);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_outputs();
      rst = 1'b0;

      for (int i = 0; i < 100; i++) step(M_EMPTY);
      run_to_frame_start(M_FULL);
      run_frame(M_FULL);
      run_frame(M_HOLE);
      run_frame(M_FULL);
      run_frame(M_RAND);
      run_frame(M_ALT);
      run_frame(M_EMPTY);
      run_frame(M_FULL);

      // Mid-frame asynchronous reset at line 5, pixel 7
      while (k != 5 * HT + 7) step(M_RAND);
      @(negedge clk);
      rst        = 1'b1;
      rd_latched = 1'b0;
      fifo_empty = 1'b1;
      #1;
      chk_reset_outputs();
      exp_q.delete();
      running  = 1'b0;
      k        = 0;
      uf_seen  = 1'b0;
      frame_uf = 0;
      exp_ucnt = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) step(M_EMPTY);
      run_to_frame_start(M_FULL);
      run_frame(M_RAND);
      run_frame(M_FULL);
      for (int i = 0; i < 4; i++) step(M_FULL);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
